axi4_rd_burst_track: RTL and testbench

- Passive in-order checker for the AXI4 read path: AR and R channels. It never drives the bus.
- Each accepted AR (ID plus length) is queued in an internal FIFO. Each R beat is checked against the queue head for ID match, exact beat count, a response with no matching request, outstanding overflow and a stall timeout.
- Sits beside any read master/slave pair whose slave returns bursts in issue order. All error flags are sticky, for simulation and debug.

---
 rtl/axi4_track_pkg.sv | 12 +
 rtl/axi4_track_fifo.sv | 57 +++++
 rtl/axi4_rd_burst_track.sv | 107 ++++++++++
 tb/tb_axi4_rd_burst_track.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_track_pkg.sv
// rtl/axi4_track_pkg.sv - shared constants and helpers for the AXI4 burst trackers
package axi4_track_pkg;

  localparam int LEN_W  = 8;
  localparam int TCNT_W = 16;

  // Saturating increment used by the stall timers
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi4_track_fifo.sv
// rtl/axi4_track_fifo.sv - synchronous FIFO holding accepted burst descriptors
module axi4_track_fifo #(
  parameter int DSIZE = 12,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DSIZE-1:0] din_i,
  input  logic             pop_i,
  output logic [DSIZE-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push needs when full
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/axi4_rd_burst_track.sv
// rtl/axi4_rd_burst_track.sv - passive in-order checker for the AXI4 AR/R channels
module axi4_rd_burst_track
  import axi4_track_pkg::*;
#(
  parameter int IDSIZE          = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int MAX_CYCLE       = 1000,
  parameter int CNTW            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic [IDSIZE-1:0] axi_arid,
  input  logic [7:0]        axi_arlen,
  input  logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [IDSIZE-1:0] axi_rid,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [CNTW-1:0]   outstanding,
  output logic              rd_overflow,
  output logic              wrong_id,
  output logic              resp_overflow,
  output logic              len_error,
  output logic              timeout_error,
  output logic              error_any
);

  typedef struct packed {
    logic [IDSIZE-1:0] id;
    logic [LEN_W-1:0]  len;
  } entry_t;

  entry_t                    head, new_entry;
  logic [$bits(entry_t)-1:0] head_raw;
  logic                      ar_hs, r_hs, at_last, pop, full, empty;
  logic [LEN_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
  logic                      rd_ovf_q, rd_ovf_d, wrong_id_q, wrong_id_d;
  logic                      resp_ovf_q, resp_ovf_d, len_err_q, len_err_d;
  logic                      tmo_q, tmo_d;

  assign ar_hs     = axi_arvalid & axi_arready;
  assign r_hs      = axi_rvalid & axi_rready;
  assign new_entry = '{id: axi_arid, len: axi_arlen};
  assign head      = entry_t'(head_raw);
  assign at_last   = (beat_cnt_q == head.len);
  assign pop       = r_hs & at_last & ~empty;

  axi4_track_fifo #(
    .DSIZE($bits(entry_t)),
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i   (axi_aclk),
    .rst_i   (axi_areset),
    .push_i  (ar_hs),
    .din_i   (new_entry),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding)
  );

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop)                beat_cnt_d = '0;
    else if (r_hs & ~empty) beat_cnt_d = beat_cnt_q + 1'b1;

    tcnt_d = (r_hs | empty) ? '0 : sat_inc(tcnt_q);

    // An AR is dropped only when full and no pop makes room this cycle
    rd_ovf_d   = rd_ovf_q   | (ar_hs & full & ~pop);
    wrong_id_d = wrong_id_q | (r_hs & ~empty & (axi_rid != head.id));
    resp_ovf_d = resp_ovf_q | (r_hs & empty);
    len_err_d  = len_err_q  | (r_hs & ~empty & (axi_rlast != at_last));
    tmo_d      = tmo_q      | (tcnt_q > TCNT_W'(MAX_CYCLE));
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      beat_cnt_q <= '0;
      tcnt_q     <= '0;
      rd_ovf_q   <= 1'b0;
      wrong_id_q <= 1'b0;
      resp_ovf_q <= 1'b0;
      len_err_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      tcnt_q     <= tcnt_d;
      rd_ovf_q   <= rd_ovf_d;
      wrong_id_q <= wrong_id_d;
      resp_ovf_q <= resp_ovf_d;
      len_err_q  <= len_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign rd_overflow   = rd_ovf_q;
  assign wrong_id      = wrong_id_q;
  assign resp_overflow = resp_ovf_q;
  assign len_error     = len_err_q;
  assign timeout_error = tmo_q;
  assign error_any     = rd_ovf_q | wrong_id_q | resp_ovf_q | len_err_q | tmo_q;

endmodule

// File: tb/tb_axi4_rd_burst_track.sv
// tb/tb_axi4_rd_burst_track.sv - self-checking bench for axi4_rd_burst_track
module tb_axi4_rd_burst_track;

  localparam int DEPTH = 16;
  localparam int MAXC  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] arid = '0, rid = '0;
  logic [7:0] arlen = '0;
  logic       arvalid = 1'b0, arready = 1'b1;
  logic       rlast = 1'b0, rvalid = 1'b0, rready = 1'b1;
  logic [4:0] outstanding;
  logic       rd_overflow, wrong_id, resp_overflow, len_error, timeout_error, error_any;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi4_rd_burst_track #(
    .IDSIZE(4), .MAX_OUTSTANDING(DEPTH), .MAX_CYCLE(MAXC), .CNTW(5)
  ) dut (
    .axi_aclk      (clk),
    .axi_areset    (rst),
    .axi_arid      (arid),
    .axi_arlen     (arlen),
    .axi_arvalid   (arvalid),
    .axi_arready   (arready),
    .axi_rid       (rid),
    .axi_rlast     (rlast),
    .axi_rvalid    (rvalid),
    .axi_rready    (rready),
    .outstanding   (outstanding),
    .rd_overflow   (rd_overflow),
    .wrong_id      (wrong_id),
    .resp_overflow (resp_overflow),
    .len_error     (len_error),
    .timeout_error (timeout_error),
    .error_any     (error_any)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending bursts plus sticky flags
  typedef struct { int id; int len; } ent_t;
  ent_t mq[$];
  int   m_beats, m_stall;
  bit   m_rdovf, m_wid, m_rspovf, m_len, m_tmo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_beats = 0; m_stall = 0;
      m_rdovf = 0; m_wid = 0; m_rspovf = 0; m_len = 0; m_tmo = 0;
    end else begin
      bit was_empty, rh, done;
      was_empty = (mq.size() == 0);
      rh = rvalid && rready;
      if (m_stall > MAXC) m_tmo = 1;
      m_stall = (rh || was_empty) ? 0 : ((m_stall < 65535) ? m_stall + 1 : m_stall);
      if (rh) begin
        if (was_empty) m_rspovf = 1;
        else begin
          done = (m_beats == mq[0].len);
          if (int'(rid) != mq[0].id) m_wid = 1;
          if (rlast != done) m_len = 1;
          if (done) begin
            void'(mq.pop_front());
            m_beats = 0;
          end else m_beats++;
        end
      end
      if (arvalid && arready) begin
        if (mq.size() < DEPTH) mq.push_back('{id: int'(arid), len: int'(arlen)});
        else m_rdovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("outstanding", 32'(outstanding), 32'(mq.size()));
    chk("rd_overflow", 32'(rd_overflow), 32'(m_rdovf));
    chk("wrong_id", 32'(wrong_id), 32'(m_wid));
    chk("resp_overflow", 32'(resp_overflow), 32'(m_rspovf));
    chk("len_error", 32'(len_error), 32'(m_len));
    chk("timeout_error", 32'(timeout_error), 32'(m_tmo));
    chk("error_any", 32'(error_any), 32'(m_rdovf | m_wid | m_rspovf | m_len | m_tmo));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic ar(input int id, input int len);
    arid = 4'(id); arlen = 8'(len); arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
  endtask

  task automatic rb(input int id, input bit last);
    rid = 4'(id); rlast = last; rvalid = 1'b1;
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    cyc(); cyc();
    chk("reset outstanding", 32'(outstanding), 32'd0);
    chk("reset error_any", 32'(error_any), 32'd0);
    rst = 1'b0;
    cyc();

    // Clean 4-beat burst with a stalled AR and an R bubble
    arready = 1'b0; arvalid = 1'b1; arid = 4'd3; arlen = 8'd3;
    cyc();
    arready = 1'b1; arvalid = 1'b0;
    chk("t1 no ar_hs", 32'(outstanding), 32'd0);
    ar(3, 3);
    chk("t1 pushed", 32'(outstanding), 32'd1);
    rb(3, 0); rb(3, 0);
    rready = 1'b0; rvalid = 1'b1; cyc(); rvalid = 1'b0; rready = 1'b1;
    rb(3, 0);
    chk("t1 before last", 32'(outstanding), 32'd1);
    rb(3, 1);
    chk("t1 popped", 32'(outstanding), 32'd0);
    chk("t1 clean", 32'(error_any), 32'd0);

    // ID mismatch, then rlast missing on final beat
    do_reset();
    ar(1, 0); ar(2, 1);
    rb(2, 1);
    chk("t2 wrong_id", 32'(wrong_id), 32'd1);
    chk("t2 len ok", 32'(len_error), 32'd0);
    rb(2, 0);
    chk("t2 len still ok", 32'(len_error), 32'd0);
    rb(1, 0);
    chk("t2 len_error", 32'(len_error), 32'd1);
    chk("t2 drained", 32'(outstanding), 32'd0);

    // Early rlast keeps the entry
    do_reset();
    ar(5, 3);
    rb(5, 0); rb(5, 1);
    chk("t3 len_error", 32'(len_error), 32'd1);
    chk("t3 kept", 32'(outstanding), 32'd1);
    rb(5, 0); rb(5, 1);
    chk("t3 popped", 32'(outstanding), 32'd0);
    chk("t3 wrong_id", 32'(wrong_id), 32'd0);

    // Fill to depth, simultaneous push/pop at full, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      arid = 4'(i); arlen = 8'd0; arvalid = 1'b1;
      cyc();
    end
    arvalid = 1'b0;
    chk("t4 full", 32'(outstanding), 32'd16);
    chk("t4 no ovf yet", 32'(rd_overflow), 32'd0);
    arid = 4'd9; arlen = 8'd0; arvalid = 1'b1;
    rid = 4'd0; rlast = 1'b1; rvalid = 1'b1;
    cyc();
    arvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    chk("t4 push+pop", 32'(outstanding), 32'd16);
    chk("t4 push+pop ovf", 32'(rd_overflow), 32'd0);
    ar(10, 0);
    chk("t4 rd_overflow", 32'(rd_overflow), 32'd1);
    chk("t4 still full", 32'(outstanding), 32'd16);

    // Response with nothing queued, and response alongside the first AR
    do_reset();
    rb(6, 1);
    chk("t5 resp_overflow a", 32'(resp_overflow), 32'd1);
    do_reset();
    arid = 4'd4; arlen = 8'd0; arvalid = 1'b1;
    rid = 4'd4; rlast = 1'b1; rvalid = 1'b1;
    cyc();
    arvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    chk("t5 resp_overflow b", 32'(resp_overflow), 32'd1);
    chk("t5 no bypass", 32'(outstanding), 32'd1);

    // Stall timeout boundary
    do_reset();
    ar(7, 0);
    for (int i = 0; i < 1001; i++) cyc();
    chk("t6 no timeout yet", 32'(timeout_error), 32'd0);
    cyc();
    chk("t6 timeout", 32'(timeout_error), 32'd1);

    // Asynchronous reset mid-burst
    do_reset();
    ar(2, 3);
    rb(2, 0);
    rb(5, 0);
    chk("t7 err before rst", 32'(error_any), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t7 async outstanding", 32'(outstanding), 32'd0);
    chk("t7 async error_any", 32'(error_any), 32'd0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
